// File: rtl/forward_layer.sv
// -----------------------------------------------------------------------------
// forward_layer
//
// Fully-connected layer engine. Captures one frame of N signed fixed-point
// inputs (W bits, Q fractional bits). Then, one neuron at a time, it fetches
// N weights plus a bias from external weight memory and multiply-accumulates
// them through a single shared multiplier. Each result is saturated to W bits
// and emitted tagged with its neuron index. All M neurons reuse the captured
// frame; the next frame is accepted only after the last result has been taken.
//
// Optional build macro:
//   FORWARD_LAYER_RELU_EN - clamp negative results to zero (no extra cycles).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_i_stb/dat/rdy     N input channels, channel k on s_i_dat[k*W+:W]
//   m_o_stb/dat/idx/rdy result stream: saturated value and neuron index
//   m_a_stb/dat/rdy     weight address stream, address = j*(N+1)+i
//   s_d_stb/dat/rdy     weight data stream (term i = N is the bias)
// -----------------------------------------------------------------------------
module forward_layer #(
    parameter  int W  = 16,
    parameter  int N  = 2,
    parameter  int M  = 4,
    parameter  int Q  = 8,
    localparam int A  = $clog2(M * (N + 1)),
    localparam int IW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        s_i_stb,
    input  logic [N*W-1:0]      s_i_dat,
    output logic [N-1:0]        s_i_rdy,
    input  logic                m_o_rdy,
    output logic                m_o_stb,
    output logic signed [W-1:0] m_o_dat,
    output logic [IW-1:0]       m_o_idx,
    input  logic                m_a_rdy,
    output logic                m_a_stb,
    output logic [A-1:0]        m_a_dat,
    input  logic                s_d_stb,
    input  logic [W-1:0]        s_d_dat,
    output logic                s_d_rdy
);

    localparam int IBW = $clog2(N + 1);

    typedef enum logic [1:0] {LOAD, ADDR, DATA, OUT} state_t;

    state_t                  state_q;
    logic [N-1:0]            cap_q;
    logic [IBW-1:0]          i_q;
    logic [IW-1:0]           j_q;
    logic signed [2*W-1:0]   acc_q;
    logic signed [W-1:0]     in_q [N];

    logic [N-1:0]            cap_xfer;
    logic                    all_cap;
    logic signed [W:0]       x_d;
    logic signed [W:0]       d_ext;
    logic signed [2*W+1:0]   prod_full;
    logic signed [2*W-1:0]   prod_d;
    logic signed [2*W-1:0]   acc_d;

    localparam logic signed [2*W-1:0] SAT_HI = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] SAT_LO = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    function automatic logic signed [W-1:0] sat(input logic signed [2*W-1:0] v);
        if (v > SAT_HI)
            sat = {1'b0, {(W-1){1'b1}}};
        else if (v < SAT_LO)
            sat = {1'b1, {(W-1){1'b0}}};
        else
            sat = v[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] act(input logic signed [W-1:0] v);
`ifdef FORWARD_LAYER_RELU_EN
        act = v[W-1] ? '0 : v;
`else
        act = v;
`endif
    endfunction

    // Stream handshakes are decoded from registered state only; the reset
    // term keeps the inputs from being accepted while rst is held.
    assign s_i_rdy  = (state_q == LOAD && !rst) ? ~cap_q : '0;
    assign m_a_stb  = (state_q == ADDR);
    assign s_d_rdy  = (state_q == DATA);
    assign m_o_stb  = (state_q == OUT);
    assign m_a_dat  = A'(int'(j_q) * (N + 1) + int'(i_q));
    assign m_o_idx  = j_q;
    assign m_o_dat  = (state_q == OUT) ? act(sat(acc_q)) : '0;

    assign cap_xfer = s_i_stb & s_i_rdy;
    // Frame completes when every channel is either already held or lands now.
    assign all_cap  = &(cap_q | cap_xfer);

    // Operand select: captured input for i < N, 1.0 for the bias term. One
    // extra bit keeps 1<<Q positive even when Q = W-1.
    always_comb begin
        x_d = (W+1)'(1) <<< Q;
        for (int k = 0; k < N; k++) begin
            if (int'(i_q) == k)
                x_d = {in_q[k][W-1], in_q[k]};
        end
    end

    assign d_ext     = {s_d_dat[W-1], s_d_dat};
    assign prod_full = x_d * d_ext;
    assign prod_d    = (2*W)'(prod_full >>> Q);
    assign acc_d     = acc_q + prod_d;

    // Input frame buffer: data only, written on channel capture.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (cap_xfer[k])
                in_q[k] <= s_i_dat[k*W +: W];
        end
    end

    // Control FSM: LOAD -> (ADDR -> DATA) x (N+1) -> OUT, repeated M times.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cap_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (all_cap) begin
                        state_q <= ADDR;
                        cap_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        acc_q   <= '0;
                    end else begin
                        cap_q   <= cap_q | cap_xfer;
                    end
                end
                ADDR: begin
                    if (m_a_rdy)
                        state_q <= DATA;
                end
                DATA: begin
                    if (s_d_stb) begin
                        acc_q <= acc_d;
                        if (i_q == IBW'(N)) begin
                            state_q <= OUT;
                        end else begin
                            i_q     <= i_q + IBW'(1);
                            state_q <= ADDR;
                        end
                    end
                end
                OUT: begin
                    if (m_o_rdy) begin
                        acc_q <= '0;
                        i_q   <= '0;
                        if (j_q == IW'(M - 1)) begin
                            j_q     <= '0;
                            state_q <= LOAD;
                        end else begin
                            j_q     <= j_q + IW'(1);
                            state_q <= ADDR;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_forward_layer.sv
module tb_forward_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s_i_stb;
    logic [31:0] s_i_dat;
    logic [1:0]  s_i_rdy;
    logic        m_o_rdy;
    logic        m_o_stb;
    logic [15:0] m_o_dat;
    logic [0:0]  m_o_idx;
    logic        m_a_rdy;
    logic        m_a_stb;
    logic [2:0]  m_a_dat;
    logic        s_d_stb;
    logic [15:0] s_d_dat;
    logic        s_d_rdy;

    int total = 0;
    int bad   = 0;

`ifdef FORWARD_LAYER_RELU_EN
    localparam logic [15:0] EXP_N1  = 16'h0000;
    localparam logic [15:0] EXP_NEG = 16'h0000;
`else
    localparam logic [15:0] EXP_N1  = 16'hFD00;
    localparam logic [15:0] EXP_NEG = 16'h8000;
`endif

    forward_layer #(.W(16), .N(2), .M(2), .Q(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_i_stb (s_i_stb),
        .s_i_dat (s_i_dat),
        .s_i_rdy (s_i_rdy),
        .m_o_rdy (m_o_rdy),
        .m_o_stb (m_o_stb),
        .m_o_dat (m_o_dat),
        .m_o_idx (m_o_idx),
        .m_a_rdy (m_a_rdy),
        .m_a_stb (m_a_stb),
        .m_a_dat (m_a_dat),
        .s_d_stb (s_d_stb),
        .s_d_dat (s_d_dat),
        .s_d_rdy (s_d_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [15:0] x0, input logic [15:0] x1);
        @(negedge clk);
        s_i_stb = 2'b11;
        s_i_dat = {x1, x0};
        chk("load_rdy", {30'd0, s_i_rdy}, 32'd3);
        @(posedge clk); #1;
        s_i_stb = 2'b00;
    endtask

    task automatic accept_addr(input int addr, input int ad, input bit lat);
        int n;
        n = 0;
        @(negedge clk);
        while (m_a_stb !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("addr_wait", {31'd0, n < 50}, 32'd1);
        if (lat) chk("addr_lat", n, 0);
        chk("addr", {29'd0, m_a_dat}, addr);
        for (int k = 0; k < ad; k++) begin
            @(negedge clk);
            chk("addr_hold", {28'd0, m_a_stb, m_a_dat}, {28'd0, 1'b1, 3'(addr)});
        end
        m_a_rdy = 1'b1;
        @(posedge clk); #1;
        m_a_rdy = 1'b0;
    endtask

    task automatic give_data(input logic [15:0] w, input int dd);
        chk("d_rdy", {31'd0, s_d_rdy}, 32'd1);
        for (int k = 0; k < dd; k++) begin
            @(negedge clk);
            chk("d_rdy_hold", {30'd0, s_d_rdy, m_a_stb}, 32'd2);
        end
        s_d_stb = 1'b1;
        s_d_dat = w;
        @(posedge clk); #1;
        s_d_stb = 1'b0;
    endtask

    task automatic take_out(input int j, input logic [15:0] exp, input int od, input bit lat);
        int n;
        n = 0;
        @(negedge clk);
        while (m_o_stb !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("out_wait", {31'd0, n < 50}, 32'd1);
        if (lat) chk("out_lat", n, 0);
        chk("out_idx", {31'd0, m_o_idx}, j);
        chk("out_dat", {16'd0, m_o_dat}, {16'd0, exp});
        for (int k = 0; k < od; k++) begin
            @(negedge clk);
            chk("out_hold", {14'd0, m_o_stb, m_o_idx, m_o_dat}, {14'd0, 1'b1, 1'(j), exp});
        end
        m_o_rdy = 1'b1;
        @(posedge clk); #1;
        m_o_rdy = 1'b0;
    endtask

    task automatic run_neuron(input int j, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] b, input logic [15:0] exp,
                              input int ad, input int dd, input int od, input bit lat);
        accept_addr(j*3 + 0, ad, lat);
        give_data(w0, dd);
        accept_addr(j*3 + 1, ad, lat);
        give_data(w1, dd);
        accept_addr(j*3 + 2, ad, lat);
        give_data(b, dd);
        take_out(j, exp, od, lat);
    endtask

    initial begin
        rst     = 1'b1;
        s_i_stb = 2'b00;
        s_i_dat = 32'd0;
        m_o_rdy = 1'b0;
        m_a_rdy = 1'b0;
        s_d_stb = 1'b0;
        s_d_dat = 16'd0;

        // Reset state: everything quiet and zero.
        repeat (2) @(negedge clk);
        chk("rst_i_rdy", {30'd0, s_i_rdy}, 32'd0);
        chk("rst_stb", {29'd0, m_a_stb, s_d_rdy, m_o_stb}, 32'd0);
        chk("rst_dat", {12'd0, m_o_dat, m_o_idx, m_a_dat}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", {30'd0, s_i_rdy}, 32'd3);

        // Basic frame, zero-wait, latency checked.
        send_frame(16'h0100, 16'h0200);
        chk("busy_no_rdy", {30'd0, s_i_rdy}, 32'd0);
        run_neuron(0, 16'h0080, 16'h0040, 16'h0100, 16'h0200, 0, 0, 0, 1'b1);
        run_neuron(1, 16'hFF00, 16'hFF00, 16'h0000, EXP_N1, 0, 0, 0, 1'b1);
        @(negedge clk);
        chk("frame_end", {29'd0, s_i_rdy, m_o_stb}, 32'd6);

        // Positive saturation; second neuron all zero weights.
        send_frame(16'h7FFF, 16'h7FFF);
        run_neuron(0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, 0, 1'b0);
        run_neuron(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1'b0);

        // Negative saturation; second neuron bias-only 1.0.
        send_frame(16'h8000, 16'h8000);
        run_neuron(0, 16'h7FFF, 16'h7FFF, 16'h8000, EXP_NEG, 0, 0, 0, 1'b0);
        run_neuron(1, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 0, 0, 0, 1'b0);

        // Input ordering: channel 1 early and repeated, channel 0 later.
        @(negedge clk);
        s_i_stb = 2'b10;
        s_i_dat = {16'h0200, 16'h0000};
        @(posedge clk); #1;
        s_i_dat = {16'h7777, 16'h0000};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ch1_held_off", {30'd0, s_i_rdy}, 32'd1);
            @(posedge clk); #1;
        end
        s_i_stb = 2'b11;
        s_i_dat = {16'h7777, 16'h0100};
        @(posedge clk); #1;
        s_i_stb = 2'b00;
        chk("order_captured", {30'd0, s_i_rdy}, 32'd0);
        run_neuron(0, 16'h0080, 16'h0040, 16'h0100, 16'h0200, 0, 0, 0, 1'b1);
        run_neuron(1, 16'hFF00, 16'hFF00, 16'h0000, EXP_N1, 0, 0, 0, 1'b1);

        // Stalls on every stream.
        send_frame(16'h0100, 16'h0200);
        run_neuron(0, 16'h0080, 16'h0040, 16'h0100, 16'h0200, 5, 7, 10, 1'b0);
        run_neuron(1, 16'hFF00, 16'hFF00, 16'h0000, EXP_N1, 5, 7, 10, 1'b0);

        // Reset during DATA of neuron 1 bias term.
        send_frame(16'h0100, 16'h0200);
        run_neuron(0, 16'h0080, 16'h0040, 16'h0100, 16'h0200, 0, 0, 0, 1'b0);
        accept_addr(3, 0, 1'b0);
        give_data(16'hFF00, 0);
        accept_addr(4, 0, 1'b0);
        give_data(16'hFF00, 0);
        accept_addr(5, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_quiet", {27'd0, s_i_rdy, m_a_stb, s_d_rdy, m_o_stb}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_after", {29'd0, s_i_rdy, m_o_stb}, 32'd6);
        send_frame(16'h0100, 16'h0200);
        run_neuron(0, 16'h0080, 16'h0040, 16'h0100, 16'h0200, 0, 0, 0, 1'b1);
        run_neuron(1, 16'hFF00, 16'hFF00, 16'h0000, EXP_N1, 0, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/forward_layer.md
# forward_layer

Fully-connected layer engine: the generalised successor to the single-neuron forward unit. It captures one frame of N signed fixed-point inputs, then time-multiplexes one multiplier across M neurons. For each neuron it fetches N weights plus a bias from external weight memory, multiply-accumulates, saturates and emits one W-bit result tagged with its neuron index. It sits between input-connection streams and the next layer's input, with weight memory on an address/data stream pair.

## Interface
- W, 16: data width, signed two's complement, Q fractional bits
- N, 2: input channels per frame (N ≥ 1)
- M, 4: neurons (outputs) per frame (M ≥ 1)
- Q, 8: fractional bits (Q < W)
- A (localparam), $clog2(M*(N+1)): weight address width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_i_stb  in  N  input channel strobes
- s_i_dat  in  N*W  input data, channel k at [k*W+:W]
- s_i_rdy  out  N  input channel ready
- m_o_rdy  in  1  output ready
- m_o_stb  out  1  output strobe
- m_o_dat  out  W  saturated neuron result
- m_o_idx  out  $clog2(M) (min 1)  neuron index of m_o_dat
- m_a_rdy  in  1  weight address ready
- m_a_stb  out  1  weight address strobe
- m_a_dat  out  A  weight address
- s_d_stb  in  1  weight data strobe
- s_d_dat  in  W  weight data
- s_d_rdy  out  1  weight data ready

## Operation
- Transfer on any stream = stb & rdy in the same cycle. A master holds stb and data stable until the transfer.
- States: LOAD, ADDR, DATA, OUT. Counters: neuron j (0..M-1), term i (0..N). Per-channel captured flags cap[N-1:0].
- LOAD: s_i_rdy[k] = ~rst & ~cap[k]. A transfer on channel k stores s_i_dat[k] and sets cap[k]. Several channels may transfer in one cycle. A second strobe on a captured channel is held off until the next frame. When all cap are set (including via the same-cycle transfers), go to ADDR with i=0, j=0, acc=0, and clear cap.
- ADDR: m_a_stb=1, m_a_dat = j*(N+1)+i. On transfer go to DATA.
- DATA: s_d_rdy=1. On transfer, operand x = input[i] for i<N; x = 1<<Q (1.0) for i=N (bias term).
  - prod = (x * s_d_dat) signed, 2W bits, arithmetic shift right by Q.
  - acc (2W signed, wraps) += prod.
  - If i<N: i++, go to ADDR. If i=N: go to OUT.
- OUT: m_o_stb=1, m_o_idx=j, m_o_dat = sat(acc), with sat clamping to [-2^(W-1), 2^(W-1)-1]. On transfer, acc=0, i=0. If j<M-1: j++, go to ADDR. If j=M-1: j=0, go to LOAD.
- Inputs are held in the buffer for all M neurons. The next frame is accepted only after the last output transfers.

## Timing
- Reset (async): state LOAD, cap=0, i=j=0, acc=0. While rst is asserted, all s_i_rdy=0 and m_a_stb=s_d_rdy=m_o_stb=0, with m_o_dat=0, m_o_idx=0, m_a_dat=0.
- Reset mid-operation: partial frame and accumulator discarded, no output emitted. The first post-reset cycle is in LOAD with s_i_rdy all 1.
- All outputs are registered or decoded from state only. No combinational path from any rdy/stb input to any output.
- Zero-wait latency: last input capture → first m_a_stb is 1 cycle. Each term takes 2 cycles (ADDR, DATA). The result appears 1 cycle after the bias weight transfers.
- Per neuron 2(N+1)+1 cycles at full throughput. Per frame M(2N+3)+N_load cycles.
- Backpressure in any state stalls that state indefinitely with outputs stable.

## Configuration
- FORWARD_LAYER_RELU_EN defined: m_o_dat = 0 when sat(acc) < 0, else sat(acc). This adds no cycles.
- Not defined: m_o_dat = sat(acc), signed result passed through.

## Test plan
- Basic (W=16, Q=8, N=2, M=2, no RELU): inputs 0x0100, 0x0200; weights n0 {0x0080, 0x0040, bias 0x0100}, n1 {0xFF00, 0xFF00, bias 0x0000} → outputs (idx0, 0x0200), (idx1, 0xFD00). Addresses issued in order 0..5.
- RELU build, same stimulus → (idx0, 0x0200), (idx1, 0x0000).
- Saturation: inputs 0x7FFF, 0x7FFF; weights 0x7FFF, 0x7FFF, bias 0x7FFF → 0x7FFF. All 0x8000 inputs with 0x7FFF weights and bias 0x8000 → 0x8000.
- Input ordering: channel 1 strobed 3 cycles before channel 0, with repeated channel-1 strobes → s_i_rdy[1] drops after the first capture, and exactly one frame is captured with correct values.
- Stalls: m_a_rdy low 5 cycles, s_d_stb delayed 7 cycles, m_o_rdy low 10 cycles → m_a_dat and m_o_dat/m_o_idx stable throughout, results identical to the basic test.
- Reset asserted during DATA of neuron 1 → all stb/rdy low immediately. After release, a fresh frame yields correct idx0 first, with no stale output.
